// File: rtl/avm_scratch_responder.sv
// Avalon-MM pipelined responder in front of a 32-bit scratch RAM, with fixed read latency and a
// waitrequest throttle on reads in flight. Define SCRATCH_BYTEEN_EN to honour byte enables on writes.
module avm_scratch_responder #(
  parameter int ADDR_W   = 10,
  parameter int DEPTH    = 1024,
  parameter int RD_LAT   = 3,
  parameter int MAX_PEND = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] slave_address,
  input  logic              slave_read,
  input  logic              slave_write,
  input  logic [31:0]       slave_writedata,
  input  logic [3:0]        slave_byteenable,
  output logic              slave_waitrequest,
  output logic [31:0]       slave_readdata,
  output logic              slave_readdatavalid,
  output logic [2:0]        pending,
  output logic              err
);
  localparam logic [ADDR_W:0] DEPTH_L    = (ADDR_W+1)'(DEPTH);
  localparam logic [2:0]      MAX_PEND_L = 3'(MAX_PEND);

  logic [31:0] mem [DEPTH];

  logic        acc, wr_acc, rd_acc, in_range;
  logic [31:0] rd_word;
  logic [2:0]  pending_next;

  logic [RD_LAT:1]        vld_pipe;
  logic [RD_LAT:1][31:0]  dat_pipe;

  // read&&write together is a protocol violation: the write wins, the read is dropped
  assign acc      = (slave_read | slave_write) & ~slave_waitrequest;
  assign wr_acc   = acc & slave_write;
  assign rd_acc   = acc & slave_read & ~slave_write;
  assign in_range = {1'b0, slave_address} < DEPTH_L;
  assign rd_word  = in_range ? mem[slave_address] : 32'hDEAD_BEEF;

  assign pending_next = pending + {2'b00, rd_acc} - {2'b00, slave_readdatavalid};

  assign slave_readdatavalid = vld_pipe[RD_LAT];
  assign slave_readdata      = dat_pipe[RD_LAT];

`ifdef SCRATCH_BYTEEN_EN
  always_ff @(posedge clk) begin
    if (wr_acc && in_range) begin
      for (int i = 0; i < 4; i++)
        if (slave_byteenable[i]) mem[slave_address][8*i +: 8] <= slave_writedata[8*i +: 8];
    end
  end
`else
  logic unused_be;
  assign unused_be = ^slave_byteenable;

  always_ff @(posedge clk) begin
    if (wr_acc && in_range) mem[slave_address] <= slave_writedata;
  end
`endif

  // RAM is sampled at acceptance; the word then rides the pipe alongside its valid bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[1] <= rd_acc;
      if (rd_acc) dat_pipe[1] <= rd_word;
      for (int i = 2; i <= RD_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending           <= '0;
      slave_waitrequest <= 1'b1;
      err               <= 1'b0;
    end else begin
      pending           <= pending_next;
      slave_waitrequest <= pending_next >= MAX_PEND_L;
      if (acc && ((slave_read && slave_write) || !in_range)) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_avm_scratch_responder.sv
// Self-checking bench for avm_scratch_responder: directed steps plus random traffic against a
// cycle-indexed transaction model (accepted reads are due at accept_cycle + RD_LAT).
module tb_avm_scratch_responder;
  localparam int ADDR_W = 10, DEPTH = 1000, RD_LAT = 3, MAX_PEND = 2;

  logic              clk = 1'b0, rst_n = 1'b0;
  logic [ADDR_W-1:0] slave_address = '0;
  logic              slave_read = 1'b0, slave_write = 1'b0;
  logic [31:0]       slave_writedata = '0;
  logic [3:0]        slave_byteenable = '0;
  logic              slave_waitrequest, slave_readdatavalid, err;
  logic [31:0]       slave_readdata;
  logic [2:0]        pending;

  always #5 clk = ~clk;

  avm_scratch_responder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT), .MAX_PEND(MAX_PEND)) dut (
    .clk(clk), .rst_n(rst_n),
    .slave_address(slave_address), .slave_read(slave_read), .slave_write(slave_write),
    .slave_writedata(slave_writedata), .slave_byteenable(slave_byteenable),
    .slave_waitrequest(slave_waitrequest), .slave_readdata(slave_readdata),
    .slave_readdatavalid(slave_readdatavalid), .pending(pending), .err(err)
  );

  typedef struct { int due; logic [31:0] data; } rsp_t;
  rsp_t        q[$];
  logic [31:0] ref_mem [int];
  int          cyc, n_cmp, n_err;
  bit          ref_err, fresh;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s @cyc %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  // One bus cycle: drive, check outputs mid-cycle against the model, then advance the model.
  task automatic step(input bit rd, input bit wr, input int addr, input logic [31:0] wd,
                      input logic [3:0] be, output bit accepted);
    bit          exp_wr, exp_rdv, in_range;
    logic [31:0] nw;
    slave_read = rd; slave_write = wr; slave_address = addr[ADDR_W-1:0];
    slave_writedata = wd; slave_byteenable = be;
    exp_wr  = fresh ? 1'b1 : (q.size() >= MAX_PEND);
    exp_rdv = (q.size() > 0) && (q[0].due == cyc);
    @(negedge clk);
    check("waitrequest", {31'b0, slave_waitrequest}, {31'b0, exp_wr});
    check("readdatavalid", {31'b0, slave_readdatavalid}, {31'b0, exp_rdv});
    check("pending", {29'b0, pending}, 32'(q.size()));
    check("err", {31'b0, err}, {31'b0, ref_err});
    if (exp_rdv) check("readdata", slave_readdata, q[0].data);
    accepted = (rd || wr) && !exp_wr;
    if (accepted) begin
      in_range = addr < DEPTH;
      if (!in_range || (rd && wr)) ref_err = 1'b1;
      if (wr && in_range) begin
`ifdef SCRATCH_BYTEEN_EN
        nw = ref_mem.exists(addr) ? ref_mem[addr] : 32'hx;
        for (int b = 0; b < 4; b++) if (be[b]) nw[8*b +: 8] = wd[8*b +: 8];
`else
        nw = wd;
`endif
        ref_mem[addr] = nw;
      end else if (rd && !wr) begin
        q.push_back('{cyc + RD_LAT, in_range ? ref_mem[addr] : 32'hDEAD_BEEF});
      end
    end
    if (exp_rdv) void'(q.pop_front());
    fresh = 1'b0;
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    slave_read = 1'b0; slave_write = 1'b0;
    q.delete(); ref_err = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_waitrequest", {31'b0, slave_waitrequest}, 32'd1);
      check("rst_readdatavalid", {31'b0, slave_readdatavalid}, 32'd0);
      check("rst_pending", {29'b0, pending}, 32'd0);
      check("rst_err", {31'b0, err}, 32'd0);
      check("rst_readdata", slave_readdata, 32'd0);
      @(posedge clk); #1;
    end
    rst_n = 1'b1; fresh = 1'b1; cyc = 0;
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(0, 0, 0, 32'h0, 4'h0, a);
  endtask

  // Issue one request, repeating it while the model says it is stalled (bounded).
  task automatic req(input bit rd, input bit wr, input int addr, input logic [31:0] wd,
                     input logic [3:0] be);
    bit a = 1'b0;
    for (int t = 0; t < 20 && !a; t++) step(rd, wr, addr, wd, be, a);
    n_cmp++;
    assert (a) else begin
      n_err++;
      $error("FAIL accept_timeout: observed 0 expected 1");
    end
  endtask

  initial begin
    bit a, hold;
    bit rd, wr;
    int addr;
    logic [31:0] wd;
    logic [3:0]  be;
    n_cmp = 0; n_err = 0; cyc = 0; fresh = 1'b1; ref_err = 1'b0;
    @(posedge clk); #1;

    // 1: reset, then waitrequest drops on the first edge after release
    do_reset();
    idle(2);

    // 2: write then read back next cycle
    req(0, 1, 5, 32'h1234_5678, 4'hF);
    req(1, 0, 5, 32'h0, 4'h0);
    idle(RD_LAT + 1);

    // 3: preload, then four back-to-back reads against MAX_PEND throttling
    for (int i = 0; i < 4; i++) req(0, 1, i, 32'hA0 + 32'(i), 4'hF);
    for (int i = 0; i < 4; i++) req(1, 0, i, 32'h0, 4'h0);
    idle(RD_LAT + 2);

    // 4: byte-lane write
    req(0, 1, 7, 32'hFFFF_FFFF, 4'hF);
    req(0, 1, 7, 32'h0000_0000, 4'b0101);
    req(1, 0, 7, 32'h0, 4'h0);
    idle(RD_LAT + 1);

    // random traffic over a small preloaded window, honouring stall-and-hold
    for (int i = 0; i < 16; i++) req(0, 1, i, $urandom, 4'hF);
    hold = 1'b0; rd = 0; wr = 0; addr = 0; wd = 0; be = 0;
    for (int i = 0; i < 300; i++) begin
      if (!hold) begin
        case ($urandom_range(0, 2))
          0: begin rd = 1; wr = 0; end
          1: begin rd = 0; wr = 1; end
          default: begin rd = 0; wr = 0; end
        endcase
        addr = $urandom_range(0, 15); wd = $urandom; be = 4'($urandom);
      end
      step(rd, wr, addr, wd, be, a);
      hold = (rd || wr) && !a;
    end
    while (hold) begin step(rd, wr, addr, wd, be, a); hold = !a; end
    idle(RD_LAT + 1);

    // 5: out-of-range read, then illegal read&&write
    req(1, 0, DEPTH, 32'h0, 4'h0);
    idle(RD_LAT + 1);
    req(1, 1, 9, 32'h55, 4'hF);
    req(1, 0, 9, 32'h0, 4'h0);
    idle(RD_LAT + 1);

    // 6: reset with two reads in flight; RAM survives
    req(1, 0, 1, 32'h0, 4'h0);
    req(1, 0, 2, 32'h0, 4'h0);
    do_reset();
    idle(RD_LAT + 2);
    req(1, 0, 5, 32'h0, 4'h0);
    idle(RD_LAT + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
